mem_wb_writeback: RTL
=====================

// Module: mem_wb_writeback
// PURPOSE
//  - MEM/WB pipeline register plus writeback logic for the RV32I 5-stage core.
//  - Captures MEM-stage results, extracts and extends load data, and selects ALU, load or PC+4.
//  - Drives the register file write port and exposes the same value as the WB->EX forwarding source.
// PARAMETERS
//  - XLEN  32  datapath width; only 32 is supported.
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     reset; asynchronous, active-low
//  stall_i        in   1     hold MEM/WB register contents
//  flush_i        in   1     kill the instruction being captured; takes priority over stall_i
//  mem_valid_i    in   1     MEM stage holds a valid instruction
//  mem_reg_wr_i   in   1     instruction writes rd
//  mem_rd_addr_i  in   5     destination register
//  mem_wb_sel_i   in   2     00 ALU, 01 load, 10 PC+4, 11 reserved
//  mem_funct3_i   in   3     load width/sign (RV32I funct3)
//  mem_addr_lo_i  in   2     byte offset of the load address
//  mem_alu_i      in   XLEN  ALU result
//  mem_pc4_i      in   XLEN  PC+4
//  mem_ldword_i   in   XLEN  raw aligned 32-bit word from data memory
//  rf_wr_en_o     out  1     register file write enable
//  rf_rd_addr_o   out  5     register file write address
//  rf_rd_data_o   out  XLEN  register file write data
//  fwd_valid_o    out  1     WB holds a live rd write (forwarding qualifier)
//  retire_o       out  1     one-cycle pulse per retired instruction
//  instret_o      out  64    retired-instruction count (WB_INSTRET_EN only)
// BEHAVIOUR
//  - Reset: all stage flops clear, wb_valid=0, done=0. All outputs are 0 during and after reset until the first capture.
//  - Capture rule, evaluated at each posedge:
//    - flush_i=1: wb_valid<=0.
//    - Else stall_i=0: capture all mem_* inputs, wb_valid<=mem_valid_i, done<=0.
//    - Else (stall only): hold all contents; done<=wb_valid.
//  - Latency: inputs sampled at edge N appear on the rf_* outputs after edge N. The register file commits them at edge N+1.
//  - live = wb_valid & ~done.
//    - rf_wr_en_o = live & wb_reg_wr & (wb_rd!=0).
//    - fwd_valid_o = rf_wr_en_o.
//    - retire_o = live.
//    - An instruction held by stall writes and retires exactly once.
//  - rf_rd_addr_o and rf_rd_data_o are driven combinationally from the stage flops, whether or not the write is enabled.
//  - Load extract, with offset = addr_lo:
//    - Byte lane = word[8*offset +: 8]; halfword lane = word[16*addr_lo[1] +: 16]. addr_lo[0] is ignored for halfwords.
//    - funct3 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
//    - Any other funct3 yields 0.
//  - wb_sel: 00 alu, 01 extracted load, 10 pc4, 11 zero.
//  - rd=0: no write and no forwarding. The instruction still retires.
//  - flush_i and stall_i together: flush wins and the stage becomes a bubble.
//  - Mid-operation rst_n assertion: outputs drop to 0 asynchronously. A pending write is lost.
// CONFIGURATION
//  - Macro WB_INSTRET_EN.
//  - Defined: 64-bit counter, reset 0, increments by 1 on every retire_o. It wraps from 2^64-1 to 0. instret_o = counter.
//  - Undefined: no counter flops are built and instret_o is tied to 0. All other behaviour is identical.
// TESTING
//  - ALU write: valid, reg_wr=1, rd=5, sel=00, alu=0x1234_5678 -> next cycle rf_wr_en=1, addr=5, data=0x1234_5678, retire=1.
//  - Loads on word 0x8081_F27F: LB off=0 -> 0x0000_007F; LB off=1 -> 0xFFFF_FFF2; LBU off=3 -> 0x0000_0080; LH off=2 -> 0xFFFF_8081; LHU off=0 -> 0x0000_F27F.
//  - rd=0, reg_wr=1, sel=10 -> rf_wr_en=0, fwd_valid=0, retire=1.
//  - Capture a JAL (sel=10, pc4=0x104, rd=1), then hold stall_i for 3 cycles -> exactly one write and one retire pulse. Outputs stay stable through the stall.
//  - flush_i and stall_i both high while mem_valid_i=1 -> next cycle wb_valid=0, no write, no retire. Assert rst_n mid-write -> rf_wr_en drops to 0 immediately.
//  - WB_INSTRET_EN: retire 10 instructions, including 2 with rd=0 and 1 stalled for 2 cycles -> instret_o=10. Preload the counter to 2^64-1 and retire one -> instret_o=0.

Source files
------------

// File: rtl/mem_wb_writeback_if.sv
// MEM -> WB stage bundle: captured MEM-stage results in, register-file write port and
// forwarding/retire status out.
interface mem_wb_writeback_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            mem_valid_i;
    logic            mem_reg_wr_i;
    logic [4:0]      mem_rd_addr_i;
    logic [1:0]      mem_wb_sel_i;
    logic [2:0]      mem_funct3_i;
    logic [1:0]      mem_addr_lo_i;
    logic [XLEN-1:0] mem_alu_i;
    logic [XLEN-1:0] mem_pc4_i;
    logic [XLEN-1:0] mem_ldword_i;

    logic            rf_wr_en_o;
    logic [4:0]      rf_rd_addr_o;
    logic [XLEN-1:0] rf_rd_data_o;
    logic            fwd_valid_o;
    logic            retire_o;
    logic [63:0]     instret_o;

    // MEM-stage side
    modport master (
        output mem_valid_i, mem_reg_wr_i, mem_rd_addr_i, mem_wb_sel_i, mem_funct3_i,
               mem_addr_lo_i, mem_alu_i, mem_pc4_i, mem_ldword_i,
        input  rf_wr_en_o, rf_rd_addr_o, rf_rd_data_o, fwd_valid_o, retire_o, instret_o
    );

    // Writeback stage side
    modport slave (
        input  mem_valid_i, mem_reg_wr_i, mem_rd_addr_i, mem_wb_sel_i, mem_funct3_i,
               mem_addr_lo_i, mem_alu_i, mem_pc4_i, mem_ldword_i,
        output rf_wr_en_o, rf_rd_addr_o, rf_rd_data_o, fwd_valid_o, retire_o, instret_o
    );
endinterface

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback mux for the RV32I core.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module mem_wb_writeback #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    mem_wb_writeback_if.slave wb
);

    localparam logic [1:0] SelAlu  = 2'b00;
    localparam logic [1:0] SelLoad = 2'b01;
    localparam logic [1:0] SelPc4  = 2'b10;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    logic            wb_valid_q;
    logic            done_q;
    logic            reg_wr_q;
    logic [4:0]      rd_q;
    logic [1:0]      sel_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] ldword_q;

    logic            live;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;

    // done_q marks an instruction already written/retired while the stage is held by stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            done_q     <= 1'b0;
            reg_wr_q   <= 1'b0;
            rd_q       <= '0;
            sel_q      <= '0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            alu_q      <= '0;
            pc4_q      <= '0;
            ldword_q   <= '0;
        end else if (flush_i) begin
            wb_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (!stall_i) begin
            wb_valid_q <= wb.mem_valid_i;
            done_q     <= 1'b0;
            reg_wr_q   <= wb.mem_reg_wr_i;
            rd_q       <= wb.mem_rd_addr_i;
            sel_q      <= wb.mem_wb_sel_i;
            funct3_q   <= wb.mem_funct3_i;
            addr_lo_q  <= wb.mem_addr_lo_i;
            alu_q      <= wb.mem_alu_i;
            pc4_q      <= wb.mem_pc4_i;
            ldword_q   <= wb.mem_ldword_i;
        end else begin
            done_q <= wb_valid_q;
        end
    end

    always_comb begin
        byte_lane = ldword_q[7:0];
        unique case (addr_lo_q)
            2'd0: byte_lane = ldword_q[7:0];
            2'd1: byte_lane = ldword_q[15:8];
            2'd2: byte_lane = ldword_q[23:16];
            2'd3: byte_lane = ldword_q[31:24];
        endcase
    end

    // Halfword loads only look at addr_lo[1]; misaligned offsets are trapped upstream.
    assign half_lane = addr_lo_q[1] ? ldword_q[31:16] : ldword_q[15:0];

    always_comb begin
        load_data = '0;
        case (funct3_q)
            F3Lb:    load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3Lh:    load_data = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3Lw:    load_data = ldword_q;
            F3Lbu:   load_data = {{(XLEN-8){1'b0}}, byte_lane};
            F3Lhu:   load_data = {{(XLEN-16){1'b0}}, half_lane};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        wb_data = '0;
        case (sel_q)
            SelAlu:  wb_data = alu_q;
            SelLoad: wb_data = load_data;
            SelPc4:  wb_data = pc4_q;
            default: wb_data = '0;
        endcase
    end

    assign live            = wb_valid_q & ~done_q;
    assign wb.rf_wr_en_o   = live & reg_wr_q & (rd_q != 5'd0);
    assign wb.fwd_valid_o  = wb.rf_wr_en_o;
    assign wb.retire_o     = live;
    assign wb.rf_rd_addr_o = rd_q;
    assign wb.rf_rd_data_o = wb_data;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (live) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign wb.instret_o = instret_q;
`else
    assign wb.instret_o = '0;
`endif

endmodule
